// File: rtl/pwm_sample_pacer_if.sv
// Sample stream handshake into the PWM pacer.
// Producer drives data/valid, pacer returns ready.
interface pwm_sample_pacer_if #(
  parameter int res = 8
);
  logic [res-1:0] s_data;
  logic           s_valid;
  logic           s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/pwm_sample_pacer.sv
// Burst-in / paced-out sample FIFO feeding the PWM generator.
// One sample released per fclkm/fs cycles; underrun is sticky.
module pwm_sample_pacer #(
  parameter int res   = 8,
  parameter int depth = 16,
  parameter int fclkm = 16000000,
  parameter int fs    = 10000,
  parameter bit hold_on_underrun = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clr_underrun,
  pwm_sample_pacer_if.slave      s,
  output logic [res-1:0]         d_out,
  output logic                   strobe,
  output logic [$clog2(depth):0] level,
  output logic                   underrun
);

  localparam int div_n = fclkm / fs;
  localparam int aw    = $clog2(depth);
  localparam int lw    = aw + 1;
  localparam int cw    = $clog2(div_n);
  localparam logic [res-1:0] mid =
    {1'b1, {(res-1){1'b0}}};

  logic [res-1:0] mem [depth];
  logic [aw-1:0]  wr_ptr;
  logic [aw-1:0]  rd_ptr;
  logic [cw-1:0]  cnt;
  logic           full;
  logic           empty;
  logic           tick;
  logic           push;
  logic           pop;

  assign full  = (level == lw'(depth));
  assign empty = (level == '0);
  assign tick  = enable && (cnt == cw'(div_n - 1));
  assign push  = s.s_valid && !full;
  assign pop   = tick && !empty;

  assign s.s_ready = !full;

  // Storage needs no reset; level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      level    <= '0;
      d_out    <= mid;
      strobe   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default:      level <= level;
      endcase
      strobe <= tick;
      if (pop) begin
        d_out <= mem[rd_ptr];
      end else if (tick && !hold_on_underrun) begin
        d_out <= mid;
      end
      // A fresh underrun beats a same-cycle clear.
      if (tick && empty) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
